// File: rtl/sdram_arbiter.sv
// Two-port SDRAM arbiter: video (read-only, fixed priority) and UART (read/write),
// one outstanding access, with an ack/data timeout. Optional UART starvation guard: SDRAM_ARB_STARVE_GUARD_EN.
module sdram_arbiter #(
  parameter int ADDR_W       = 25,
  parameter int DATA_W       = 16,
  parameter int ACK_TIMEOUT  = 255,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  input  logic              uart_req,
  input  logic              uart_we,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [DATA_W-1:0] uart_wdata,
  output logic              uart_gnt,
  output logic [DATA_W-1:0] uart_rdata,
  output logic              uart_rvalid,
  output logic              uart_wdone,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic [1:0]        mem_cmd_ack,
  input  logic              mem_rd_valid,
  input  logic              mem_wr_valid,
  output logic              timeout_err
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  typedef struct packed {
    logic              vid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t        state, state_nxt;
  req_t          lat;
  logic [TW-1:0] tmr;
  logic          starved, pick_uart, any_req;
  logic          ack_hit, done_hit, tmo;

`ifdef SDRAM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  logic [SW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 wait_cnt <= '0;
    else if (uart_gnt)                          wait_cnt <= '0;
    else if (uart_req && wait_cnt != STARVE_MAX) wait_cnt <= wait_cnt + 1'b1;
  end

  assign starved = (wait_cnt == STARVE_MAX);
`else
  assign starved = 1'b0;
`endif

  assign any_req   = vid_req | uart_req;
  assign pick_uart = uart_req & (~vid_req | starved);
  // Only the ack/valid that matches the latched direction counts.
  assign ack_hit   = lat.we ? mem_cmd_ack[0] : mem_cmd_ack[1];
  assign done_hit  = lat.we ? mem_wr_valid : mem_rd_valid;
  assign tmo       = (tmr == TMO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (any_req) state_nxt = ISSUE;
      ISSUE:     if (ack_hit) state_nxt = WAIT_DONE;
                 else if (tmo) state_nxt = IDLE;
      WAIT_DONE: if (done_hit || tmo) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_cmd  = 2'b00;
    mem_addr = lat.addr;
    mem_din  = lat.wdata;
    if (state == ISSUE) mem_cmd = lat.we ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat         <= '0;
      tmr         <= '0;
      vid_gnt     <= 1'b0;
      uart_gnt    <= 1'b0;
      vid_rvalid  <= 1'b0;
      uart_rvalid <= 1'b0;
      uart_wdone  <= 1'b0;
      vid_rdata   <= '0;
      uart_rdata  <= '0;
      timeout_err <= 1'b0;
    end else begin
      vid_gnt     <= (state == ISSUE) && ack_hit &&  lat.vid;
      uart_gnt    <= (state == ISSUE) && ack_hit && !lat.vid;
      vid_rvalid  <= 1'b0;
      uart_rvalid <= 1'b0;
      uart_wdone  <= 1'b0;

      if (state == IDLE && any_req) begin
        lat.vid   <= ~pick_uart;
        lat.we    <= pick_uart & uart_we;
        lat.addr  <= pick_uart ? uart_addr : vid_addr;
        lat.wdata <= pick_uart ? uart_wdata : '0;
      end

      // Timer restarts on every state change and only advances while busy.
      if (state != state_nxt || state == IDLE) tmr <= '0;
      else                                     tmr <= tmr + 1'b1;

      if (state == WAIT_DONE && done_hit) begin
        if (lat.we)       uart_wdone <= 1'b1;
        else if (lat.vid) begin vid_rvalid  <= 1'b1; vid_rdata  <= mem_dout; end
        else              begin uart_rvalid <= 1'b1; uart_rdata <= mem_dout; end
      end

      if (((state == ISSUE) && !ack_hit && tmo) ||
          ((state == WAIT_DONE) && !done_hit && tmo))
        timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: write, priority, wrong ack, timeout, reset mid-read, starvation.
module tb_sdram_arbiter;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              vid_req, vid_gnt, vid_rvalid;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_rdata;
  logic              uart_req, uart_we, uart_gnt, uart_rvalid, uart_wdone;
  logic [ADDR_W-1:0] uart_addr;
  logic [DATA_W-1:0] uart_wdata, uart_rdata;
  logic [1:0]        mem_cmd, mem_cmd_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din, mem_dout;
  logic              mem_rd_valid, mem_wr_valid, timeout_err;

  int checks = 0;
  int errors = 0;

  sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACK_TIMEOUT(8), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
    .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr),
    .uart_wdata(uart_wdata), .uart_gnt(uart_gnt), .uart_rdata(uart_rdata),
    .uart_rvalid(uart_rvalid), .uart_wdone(uart_wdone),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_cmd_ack(mem_cmd_ack), .mem_rd_valid(mem_rd_valid), .mem_wr_valid(mem_wr_valid),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int ugnt, vgnt;
    reset = 1'b0; vid_req = 0; vid_addr = '0; uart_req = 0; uart_we = 0;
    uart_addr = '0; uart_wdata = '0; mem_dout = '0; mem_cmd_ack = 2'b00;
    mem_rd_valid = 0; mem_wr_valid = 0;
    tick(); tick();
    chk("rst_cmd", 32'(mem_cmd), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    chk("rst_vrd", 32'(vid_rdata), 0);
    reset = 1'b1;
    tick();

    // Single UART write
    uart_req = 1; uart_we = 1; uart_addr = 25'h00010; uart_wdata = 16'hA5C3;
    tick();
    chk("wr_cmd", 32'(mem_cmd), 32'h1);
    chk("wr_addr", 32'(mem_addr), 32'h10);
    chk("wr_din", 32'(mem_din), 32'hA5C3);
    tick(); tick();
    chk("wr_cmd_hold", 32'(mem_cmd), 32'h1);
    chk("wr_gnt_early", 32'(uart_gnt), 0);
    mem_cmd_ack = 2'b01;
    tick();
    chk("wr_gnt", 32'(uart_gnt), 1);
    chk("wr_cmd_drop", 32'(mem_cmd), 0);
    mem_cmd_ack = 2'b00; uart_req = 0;
    tick();
    chk("wr_gnt_once", 32'(uart_gnt), 0);
    mem_wr_valid = 1;
    tick();
    chk("wr_wdone", 32'(uart_wdone), 1);
    mem_wr_valid = 0;
    tick();
    chk("wr_wdone_once", 32'(uart_wdone), 0);

    // Simultaneous requests: video first
    vid_req = 1; vid_addr = 25'h00100;
    uart_req = 1; uart_we = 0; uart_addr = 25'h00200;
    tick();
    chk("pri_cmd", 32'(mem_cmd), 32'h2);
    chk("pri_addr", 32'(mem_addr), 32'h100);
    mem_cmd_ack = 2'b10;
    tick();
    chk("pri_vgnt", 32'(vid_gnt), 1);
    chk("pri_ugnt", 32'(uart_gnt), 0);
    vid_req = 0; mem_cmd_ack = 2'b00;
    tick();
    mem_dout = 16'h1234; mem_rd_valid = 1;
    tick();
    chk("pri_vrv", 32'(vid_rvalid), 1);
    chk("pri_vrd", 32'(vid_rdata), 32'h1234);
    chk("pri_urv", 32'(uart_rvalid), 0);
    mem_rd_valid = 0;
    tick();
    chk("pri_vrv_once", 32'(vid_rvalid), 0);
    chk("u2_cmd", 32'(mem_cmd), 32'h2);
    chk("u2_addr", 32'(mem_addr), 32'h200);

    // Wrong ack ignored
    mem_cmd_ack = 2'b01;
    tick();
    chk("wack_cmd", 32'(mem_cmd), 32'h2);
    chk("wack_gnt", 32'(uart_gnt), 0);
    mem_cmd_ack = 2'b10;
    tick();
    chk("u2_gnt", 32'(uart_gnt), 1);
    mem_cmd_ack = 2'b00; uart_req = 0;
    tick();
    mem_dout = 16'hBEEF; mem_rd_valid = 1;
    tick();
    chk("u2_rv", 32'(uart_rvalid), 1);
    chk("u2_rd", 32'(uart_rdata), 32'hBEEF);
    chk("vrd_hold", 32'(vid_rdata), 32'h1234);
    // Stray valid in IDLE
    mem_dout = 16'h5555;
    tick();
    chk("idle_rv", 32'(uart_rvalid), 0);
    chk("idle_rd", 32'(uart_rdata), 32'hBEEF);
    mem_rd_valid = 0;
    tick();

    // Ack timeout
    uart_req = 1; uart_we = 0; uart_addr = 25'h00300;
    tick();
    chk("to_cmd", 32'(mem_cmd), 32'h2);
    uart_req = 0;
    for (int i = 0; i < 7; i++) tick();
    chk("to_cmd_7", 32'(mem_cmd), 32'h2);
    chk("to_err_7", 32'(timeout_err), 0);
    tick();
    chk("to_cmd_8", 32'(mem_cmd), 0);
    chk("to_err", 32'(timeout_err), 1);
    chk("to_gnt", 32'(uart_gnt), 0);
    vid_req = 1; vid_addr = 25'h00400;
    tick();
    chk("to_next_cmd", 32'(mem_cmd), 32'h2);
    chk("to_next_addr", 32'(mem_addr), 32'h400);
    chk("to_err_sticky", 32'(timeout_err), 1);
    mem_cmd_ack = 2'b10;
    tick();
    chk("to_next_gnt", 32'(vid_gnt), 1);
    vid_req = 0; mem_cmd_ack = 2'b00;
    tick();

    // Reset mid-read in WAIT_DONE
    #2 reset = 1'b0;
    #1;
    chk("rr_cmd", 32'(mem_cmd), 0);
    chk("rr_addr", 32'(mem_addr), 0);
    chk("rr_terr", 32'(timeout_err), 0);
    chk("rr_vrd", 32'(vid_rdata), 0);
    chk("rr_urd", 32'(uart_rdata), 0);
    mem_dout = 16'h7777; mem_rd_valid = 1;
    tick();
    chk("rr_vrv", 32'(vid_rvalid), 0);
    reset = 1'b1;
    tick();
    chk("rr_vrv2", 32'(vid_rvalid), 0);
    mem_rd_valid = 0;
    uart_req = 1; uart_we = 1; uart_addr = 25'h00050; uart_wdata = 16'h0F0F;
    tick();
    chk("rr_idle_cmd", 32'(mem_cmd), 32'h1);
    chk("rr_idle_din", 32'(mem_din), 32'h0F0F);
    uart_req = 0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Starvation: video hogs, controller always responds
    ugnt = 0; vgnt = 0;
    vid_req = 1; uart_req = 1; uart_we = 0;
    mem_cmd_ack = 2'b11; mem_rd_valid = 1; mem_wr_valid = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (uart_gnt) ugnt++;
      if (vid_gnt) vgnt++;
    end
    chk("st_vgnt_seen", 32'(vgnt > 0), 1);
`ifdef SDRAM_ARB_STARVE_GUARD_EN
    chk("st_ugnt_seen", 32'(ugnt > 0), 1);
`else
    chk("st_ugnt_none", 32'(ugnt), 0);
`endif
    vid_req = 0; uart_req = 0; mem_cmd_ack = 2'b00; mem_rd_valid = 0; mem_wr_valid = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
